// File: rtl/decoder_onehot_skid.sv
// Index-to-one-hot/thermometer decoder with valid/ready handshakes on both sides,
// decoupled by a 2-entry skid buffer so in_ready never depends on out_ready combinationally.
module decoder_onehot_skid #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_index,
  input  logic             in_thermo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
  output logic             out_error
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [IDX_W:0] WIDTH_L = (IDX_W + 1)'(WIDTH);

  // Returns {vec, err}; out-of-range indices yield an all-zero vector with err set.
  function automatic logic [WIDTH:0] decode_word(input logic [IDX_W-1:0] idx,
                                                 input logic             thermo);
    logic [WIDTH-1:0] vec;
    logic             err;
    vec = '0;
    err = 1'b0;
    if ({1'b0, idx} >= WIDTH_L) begin
      err = 1'b1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (thermo) begin
          vec[i] = (32'(i) <= 32'(idx));
        end else begin
          vec[i] = (32'(i) == 32'(idx));
        end
      end
    end
    return {vec, err};
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH:0]   head_r;
  logic [WIDTH:0]   skid_r;
  logic [WIDTH:0]   dec_word_s;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             in_fire_s;
  logic             out_fire_s;

  assign dec_word_s = decode_word(in_index, in_thermo);
  assign in_fire_s  = in_valid && in_ready_r;
  assign out_fire_s = out_valid_r && out_ready;

  // Occupancy next-state from the two handshakes.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (in_fire_s) begin
          state_next_s = ONE;
        end else begin
          state_next_s = EMPTY;
        end
      end
      ONE: begin
        if (in_fire_s && !out_fire_s) begin
          state_next_s = TWO;
        end else if (!in_fire_s && out_fire_s) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = ONE;
        end
      end
      TWO: begin
        if (out_fire_s) begin
          state_next_s = ONE;
        end else begin
          state_next_s = TWO;
        end
      end
      default: begin
        state_next_s = EMPTY;
      end
    endcase
  end

  // State register and registered handshake flags derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s != EMPTY);
      in_ready_r  <= (state_next_s != TWO);
    end
  end

  // Head/skid data path: new words land in the head when it is free or being drained,
  // otherwise in the skid entry, which moves forward when the head drains in TWO.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= '0;
      skid_r <= '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            head_r <= dec_word_s;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            head_r <= dec_word_s;
          end else if (in_fire_s) begin
            skid_r <= dec_word_s;
          end
        end
        TWO: begin
          if (out_fire_s) begin
            head_r <= skid_r;
          end
        end
        default: begin
          head_r <= '0;
          skid_r <= '0;
        end
      endcase
    end
  end

  assign out_vec   = head_r[WIDTH:1];
  assign out_error = head_r[0];
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;

endmodule

// File: tb/tb_decoder_onehot_skid.sv
// Directed bench for decoder_onehot_skid: a WIDTH=16 instance and a WIDTH=10 instance
// share stimulus; outputs are sampled on the falling edge.
module tb_decoder_onehot_skid;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_index;
  logic        in_thermo;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_vec;
  logic        out_error;

  logic        in_ready10;
  logic        out_valid10;
  logic [9:0]  out_vec10;
  logic        out_error10;

  int errors = 0;
  int checks = 0;

  decoder_onehot_skid #(.WIDTH(16), .IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_index  (in_index),
    .in_thermo (in_thermo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_error (out_error)
  );

  decoder_onehot_skid #(.WIDTH(10), .IDX_W(4)) dut10 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready10),
    .in_index  (in_index),
    .in_thermo (in_thermo),
    .out_valid (out_valid10),
    .out_ready (out_ready),
    .out_vec   (out_vec10),
    .out_error (out_error10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_index  = 4'd0;
    in_thermo = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_vec",   32'(out_vec),   32'h0);
    chk("rst_out_error", 32'(out_error), 32'd0);
    rst = 1'b0;

    // Basic decode and streaming replacement in ONE
    in_valid = 1'b1; in_index = 4'd5; in_thermo = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("idx5_valid", 32'(out_valid), 32'd1);
    chk("idx5_vec",   32'(out_vec),   32'h0020);
    chk("idx5_err",   32'(out_error), 32'd0);
    in_index = 4'd3; in_thermo = 1'b1;
    @(negedge clk);
    chk("th3_vec", 32'(out_vec), 32'h000F);
    in_index = 4'd15; in_thermo = 1'b1;
    @(negedge clk);
    chk("th15_vec", 32'(out_vec), 32'hFFFF);
    in_index = 4'd12; in_thermo = 1'b0;
    @(negedge clk);
    chk("w16_idx12_vec", 32'(out_vec),     32'h1000);
    chk("w10_idx12_vec", 32'(out_vec10),   32'h000);
    chk("w10_idx12_err", 32'(out_error10), 32'd1);
    in_index = 4'd12; in_thermo = 1'b1;
    @(negedge clk);
    chk("w10_th12_vec", 32'(out_vec10),   32'h000);
    chk("w10_th12_err", 32'(out_error10), 32'd1);
    in_index = 4'd9; in_thermo = 1'b0;
    @(negedge clk);
    chk("w10_idx9_vec", 32'(out_vec10),   32'h200);
    chk("w10_idx9_err", 32'(out_error10), 32'd0);
    chk("w16_idx9_vec", 32'(out_vec),     32'h0200);
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_ready", 32'(in_ready),  32'd1);

    // Back-pressure fills the skid entry
    out_ready = 1'b0; in_valid = 1'b1; in_index = 4'd1;
    @(negedge clk);
    chk("bp1_vec",   32'(out_vec),  32'h0002);
    chk("bp1_ready", 32'(in_ready), 32'd1);
    in_index = 4'd2;
    @(negedge clk);
    chk("bp2_ready", 32'(in_ready), 32'd0);
    chk("bp2_vec",   32'(out_vec),  32'h0002);
    in_index = 4'd7;
    @(negedge clk);
    chk("bp_hold_vec",   32'(out_vec),   32'h0002);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_ready", 32'(in_ready),  32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("skid_vec",   32'(out_vec),   32'h0004);
    chk("skid_valid", 32'(out_valid), 32'd1);
    chk("skid_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    chk("skid_empty", 32'(out_valid), 32'd0);

    // Full-rate streaming of every index
    in_valid = 1'b1; in_thermo = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_index = 4'(i);
      @(negedge clk);
      chk("stream_vec",   32'(out_vec),   32'd1 << i);
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_ready", 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_end", 32'(out_valid), 32'd0);

    // Reset while holding two words
    out_ready = 1'b0; in_valid = 1'b1; in_index = 4'd10;
    @(negedge clk);
    in_index = 4'd11;
    @(negedge clk);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1; out_ready = 1'b1; in_index = 4'd4;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    chk("mid_rst_vec",   32'(out_vec),   32'h0);
    chk("mid_rst_err",   32'(out_error), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("post_rst_valid2", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
